// File: rtl/ebus_xfer.sv
// EBUS transfer sequencer: turns a one-cycle EBOX request into the DEMAND/TRANSFER
// handshake, drives the address/write-data registers and captures read data.
module ebus_xfer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        CROBAR_N,
  input  logic        req,
  input  logic [6:0]  reqCS,
  input  logic [2:0]  reqFunc,
  input  logic        reqIsRead,
  input  logic [35:0] reqData,
  input  logic        ebusTransfer,
  input  logic [35:0] ebusData,
  output logic [6:0]  ebusCS,
  output logic [2:0]  ebusFunc,
  output logic        ebusDemand,
  output logic        ebusDriveEbox,
  output logic [35:0] ebusDataOut,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [35:0] rdData
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_DEMAND  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // The counter holds edges already waited, so the abort edge is the one seeing TIMEOUT-1.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  cs_q, cs_d;
  logic [2:0]  func_q, func_d;
  logic [35:0] dout_q, dout_d;
  logic        drive_q, drive_d;
  logic        is_read_q, is_read_d;
  logic        demand_q, demand_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [35:0] rd_q, rd_d;
  logic        go_idle_s;
  logic        cnt_last_s;

  // Next-state and next-output logic for the handshake sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cs_d       = cs_q;
    func_d     = func_q;
    dout_d     = dout_q;
    drive_d    = drive_q;
    is_read_d  = is_read_q;
    demand_d   = demand_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    rd_d       = rd_q;
    go_idle_s  = 1'b0;
    cnt_last_s = (cnt_q == CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d   = ST_SETUP;
          busy_d    = 1'b1;
          cs_d      = reqCS;
          func_d    = reqFunc;
          dout_d    = reqData;
          is_read_d = reqIsRead;
          drive_d   = ~reqIsRead;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d  = ST_DEMAND;
        demand_d = 1'b1;
        cnt_d    = 16'd0;
      end
      ST_DEMAND: begin
        if (ebusTransfer) begin
          if (is_read_q) begin
            rd_d = ebusData;
          end else begin
            rd_d = rd_q;
          end
          demand_d = 1'b0;
          cnt_d    = 16'd0;
          state_d  = ST_RELEASE;
        end else if (cnt_last_s) begin
          timeout_d = 1'b1;
          go_idle_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        if (!ebusTransfer) begin
          done_d    = 1'b1;
          go_idle_s = 1'b1;
        end else if (cnt_last_s) begin
          timeout_d = 1'b1;
          go_idle_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase

    // Any return to IDLE drops the whole bus side; rdData is deliberately kept.
    if (go_idle_s) begin
      state_d   = ST_IDLE;
      cnt_d     = 16'd0;
      cs_d      = 7'd0;
      func_d    = 3'd0;
      dout_d    = 36'd0;
      drive_d   = 1'b0;
      is_read_d = 1'b0;
      demand_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      busy_d = busy_d;
    end
  end

  // State and output registers, cleared asynchronously by CROBAR.
  always_ff @(posedge clk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      cs_q      <= 7'd0;
      func_q    <= 3'd0;
      dout_q    <= 36'd0;
      drive_q   <= 1'b0;
      is_read_q <= 1'b0;
      demand_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rd_q      <= 36'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cs_q      <= cs_d;
      func_q    <= func_d;
      dout_q    <= dout_d;
      drive_q   <= drive_d;
      is_read_q <= is_read_d;
      demand_q  <= demand_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      rd_q      <= rd_d;
    end
  end

  assign ebusCS        = cs_q;
  assign ebusFunc      = func_q;
  assign ebusDemand    = demand_q;
  assign ebusDriveEbox = drive_q;
  assign ebusDataOut   = dout_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign rdData        = rd_q;

endmodule

// File: doc/ebus_xfer.md
# ebus_xfer

EBUS transfer sequencer for the KL10 model. It turns a single-cycle EBOX request (controller select, function, direction, write data) into the EBUS DEMAND/TRANSFER handshake. It tells the EBOX-side driver when to place write data on the bus, and it captures read data from the multiplexed EBUS data lines. It is the stage that sequences what the top-level EBUS data mux carries: its `ebusDriveEbox` output enables the EBOX driver into that mux, and its `ebusData` input is the mux output.

## Interface
- `TIMEOUT`, default 255: number of consecutive sampling edges without the expected TRANSFER level before the transfer is aborted. Legal range is 2..65535; the counter is 16 bits.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `CROBAR_N` in 1: reset, asynchronous and active-low.
- `req` in 1: single-cycle transfer request. Honoured only in IDLE.
- `reqCS` in 7: controller select [0:6].
- `reqFunc` in 3: EBUS function [0:2].
- `reqIsRead` in 1: 1 means the device drives data; 0 means EBOX drives data.
- `reqData` in 36: write data [0:35].
- `ebusTransfer` in 1: TRANSFER from the addressed device.
- `ebusData` in 36: multiplexed EBUS data.
- `ebusCS` out 7: controller select on the bus.
- `ebusFunc` out 3: function on the bus.
- `ebusDemand` out 1: DEMAND.
- `ebusDriveEbox` out 1: enables the EBOX EBUS driver.
- `ebusDataOut` out 36: write data presented to the EBOX driver.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `timeout` out 1: one-cycle pulse on abort.
- `rdData` out 36: last captured read data.

## Operation
- All outputs are registered. Async reset drives every output to 0, sets state to IDLE and clears the counter.
- **IDLE:** bus outputs are 0 and `busy`=0. On an edge with `req`=1:
  - Latch cs, func, isRead and data.
  - Go to SETUP with `busy`=1.
  - Drive `ebusCS`, `ebusFunc` and `ebusDataOut` from the latched values.
  - Set `ebusDriveEbox`=~isRead.
- **SETUP:** lasts exactly 1 cycle so the address settles before DEMAND. Next state is DEMAND with `ebusDemand`=1 and the counter cleared.
- **DEMAND:** `ebusTransfer` is sampled at each edge.
  - If it is 1: capture `ebusData` into `rdData` (reads only), set `ebusDemand`=0, clear the counter and go to RELEASE.
  - Otherwise increment the counter.
  - On the TIMEOUT-th consecutive edge without TRANSFER: set `ebusDemand`=0, `timeout`=1, go to IDLE, clear the bus outputs and set `busy`=0.
- **RELEASE:** wait for `ebusTransfer`=0.
  - When it is 0: `done`=1, go to IDLE, clear the bus outputs and set `busy`=0.
  - After TIMEOUT consecutive edges still seeing 1: `timeout`=1, go to IDLE, and `done` is not asserted.
- `ebusCS`, `ebusFunc`, `ebusDataOut` and `ebusDriveEbox` stay stable from SETUP through RELEASE.
- `rdData` changes only on a read capture. It is unchanged by writes and by timeouts.
- `req` while `busy`=1 is ignored and is not queued.
- `done` and `timeout` are never asserted together.

## Timing
- Edge numbering: e0 is the edge that samples `req`=1.
- After e0: state SETUP, `busy`=1, address valid.
- After e1: `ebusDemand`=1.
- The first TRANSFER sample is at e2.
- Minimum latency: TRANSFER=1 at e2 and TRANSFER=0 at e3 gives `done` high in the cycle after e3. That is 4 edges from request to done.
- `rdData` is valid from the cycle after the capture edge. It is guaranteed valid when `done` is seen.
- Timeout with TRANSFER never asserted: `timeout` is high in the cycle after e(1+TIMEOUT).
- Back-to-back: `req` sampled at the edge following the `done` cycle is accepted, because the state is already IDLE during the `done` cycle.
- TRANSFER already high at e2 (stale device) is treated as a valid handshake.
- Reset asserted mid-transfer: `ebusDemand` and `ebusDriveEbox` fall asynchronously, with no `done` or `timeout` pulse.

## Test plan
- **Write:** `req` with cs=7'o4, func=3'd1, isRead=0, data=36'o123456701234; device raises TRANSFER at e3 and drops it at e5 -> `ebusDriveEbox`=1 and `ebusDataOut`=36'o123456701234 from after e0 through RELEASE; `ebusDemand` is high after e1..e3; `done` pulses after e5; `rdData` stays 0.
- **Read:** isRead=1, device drives `ebusData`=36'o777000111222 and TRANSFER at e2, drops it at e3 -> `ebusDriveEbox`=0; `rdData`=36'o777000111222; `done` pulses after e3 (minimum latency).
- **DEMAND timeout:** TIMEOUT=8 and TRANSFER held 0 -> `timeout` pulses after e9; `ebusDemand` is 0 after e9; `busy`=0; `done` is never high; `rdData` is unchanged.
- **RELEASE timeout:** TIMEOUT=8, TRANSFER rises at e2 and is stuck high -> `timeout` pulses after e10; no `done`.
- **Ignored and back-to-back requests:** a second `req` at e1 is ignored and `ebusCS` keeps the first value. A `req` issued during the `done` cycle is accepted, and a new SETUP starts after that edge.
- **Reset mid-transfer:** `CROBAR_N` goes low during DEMAND -> all outputs are 0 immediately. After release, a new `req` completes normally.
